// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Parametrised VGA raster timing generator. Divides the system clock into a
// pixel clock-enable and walks an (xPixel, yPixel) raster across the full
// H_TOTAL x V_TOTAL frame, producing sync, blanking, frame/line strobes and a
// completed-frame counter.
//
// Ports
//   clk           system clock
//   rst           asynchronous reset, active-high
//   enable        1 = raster advances, 0 = everything frozen (divider included)
//   pix_ce        pixel clock-enable (combinational from divider phase)
//   xPixel        horizontal position, CW bits
//   yPixel        vertical position, CW bits
//   hsync/vsync   sync pulses, asserted level HS_POL / VS_POL
//   active_pixels high inside the visible H_ACTIVE x V_ACTIVE window
//   VGA_BLANK_N   same as active_pixels
//   VGA_SYNC_N    tied high
//   sof           one-clk strobe after the raster lands on (0,0)
//   eol           last pixel of a line being consumed (combinational)
//   frame_cnt     completed frames, wraps at 2^16
module vga_timing_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter int   CLK_DIV  = 2,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  output logic          pix_ce,
  output logic [CW-1:0] xPixel,
  output logic [CW-1:0] yPixel,
  output logic          hsync,
  output logic          vsync,
  output logic          active_pixels,
  output logic          VGA_BLANK_N,
  output logic          VGA_SYNC_N,
  output logic          sof,
  output logic          eol,
  output logic [15:0]   frame_cnt
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic [15:0]   frame_q, frame_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          active_q, active_d;
  logic          sof_q, sof_d;

  // With CLK_DIV=1 the divider is stuck at 0 == DIV_LAST, so pix_ce = enable.
  assign pix_ce = enable & (div_cnt_q == DIV_LAST);
  assign eol    = pix_ce & (x_q == H_LAST);

  always_comb begin
    div_cnt_d = div_cnt_q;
    x_d       = x_q;
    y_d       = y_q;
    frame_d   = frame_q;

    if (enable) begin
      div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
    end

    if (pix_ce) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d     = '0;
          frame_d = frame_q + 16'd1;
        end else begin
          y_d = y_q + CW'(1);
        end
      end else begin
        x_d = x_q + CW'(1);
      end
    end

    // Decoded from the next counter values so the registered outputs land on
    // the same edge as the counters. While frozen, x_d/y_d equal the current
    // values, so these simply re-register what is already held.
    hsync_d  = ((int'(x_d) >= HS_START) && (int'(x_d) < HS_END)) ? HS_POL : ~HS_POL;
    vsync_d  = ((int'(y_d) >= VS_START) && (int'(y_d) < VS_END)) ? VS_POL : ~VS_POL;
    active_d = (int'(x_d) < H_ACTIVE) && (int'(y_d) < V_ACTIVE);
    sof_d    = pix_ce && (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= '0;
      x_q       <= '0;
      y_q       <= '0;
      frame_q   <= '0;
      hsync_q   <= ~HS_POL;
      vsync_q   <= ~VS_POL;
      active_q  <= 1'b1;
      sof_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      frame_q   <= frame_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      active_q  <= active_d;
      sof_q     <= sof_d;
    end
  end

  assign xPixel        = x_q;
  assign yPixel        = y_q;
  assign frame_cnt     = frame_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign active_pixels = active_q;
  assign VGA_BLANK_N   = active_q;
  assign VGA_SYNC_N    = 1'b1;
  assign sof           = sof_q;

endmodule
